// File: rtl/mem_stage_mq.sv
// mem_stage_mq: multi-entry MEM stage; matches in-order load responses, extracts sub-word data,
// and drops responses for loads cancelled by a WB flush. Option: MS_RDATA_BYPASS_EN.
module mem_stage_mq #(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned SIDE_W = 64,
  parameter int unsigned CNT_W  = $clog2(DEPTH) + 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              es_to_ms_valid,
  output logic              ms_allowin,
  input  logic [31:0]       es_pc,
  input  logic [31:0]       es_alu_result,
  input  logic [4:0]        es_dest,
  input  logic              es_gr_we,
  input  logic [2:0]        es_ld_type,
  input  logic              es_ex,
  input  logic              es_eret,
  input  logic [SIDE_W-1:0] es_side,
  input  logic              ws_allowin,
  output logic              ms_to_ws_valid,
  output logic [31:0]       ms_pc,
  output logic [31:0]       ms_final_result,
  output logic [3:0]        ms_rf_we,
  output logic [4:0]        ms_dest,
  output logic              ms_ex,
  output logic [SIDE_W-1:0] ms_side,
  output logic              ms_handle_ex,
  input  logic [31:0]       data_sram_rdata,
  input  logic              data_sram_dataok,
  input  logic              ws_handle_ex,
  output logic [CNT_W-1:0]  ms_ld_outstanding
);

  localparam int unsigned PW = $clog2(DEPTH);

  typedef enum logic [2:0] {LdNone, LdLb, LdLbu, LdLh, LdLhu, LdLw, LdLwl, LdLwr} ld_e;

  typedef struct packed {
    logic              valid;
    logic              is_load;
    logic              data_vld;
    logic [31:0]       pc;
    logic [31:0]       alu;
    logic [4:0]        dest;
    logic              gr_we;
    ld_e               ld_type;
    logic              ex;
    logic              eret;
    logic [SIDE_W-1:0] side;
    logic [31:0]       data;
  } ent_t;

  ent_t             ent_q [DEPTH];
  ent_t             ent_d [DEPTH];
  logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d, drop_q, drop_d;

  logic             push, pop, consume, drop_dec, tgt_found, byp_hit, head_done;
  logic [PW-1:0]    tgt_idx, scan_idx;
  logic [CNT_W-1:0] wait_cnt;
  ent_t             head;
  logic [31:0]      ld_data, res;
  logic [3:0]       we;
  logic [1:0]       ld_off;
  logic [7:0]       sel_byte;
  logic [15:0]      sel_half;

  assign ms_allowin = (count_q != CNT_W'(DEPTH));
  assign push       = es_to_ms_valid && ms_allowin;
  assign pop        = ms_to_ws_valid && ws_allowin;
  assign consume    = data_sram_dataok && (drop_q == '0) && tgt_found;
  assign drop_dec   = data_sram_dataok && (drop_q != '0);

  // Scan from head so the first hit is the oldest load still waiting for data.
  always_comb begin
    tgt_found = 1'b0;
    tgt_idx   = head_q;
    scan_idx  = head_q;
    wait_cnt  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = head_q + PW'(i);
      if (!tgt_found && ent_q[scan_idx].valid && ent_q[scan_idx].is_load &&
          !ent_q[scan_idx].data_vld) begin
        tgt_found = 1'b1;
        tgt_idx   = scan_idx;
      end
      if (ent_q[i].valid && ent_q[i].is_load && !ent_q[i].data_vld) begin
        wait_cnt = wait_cnt + CNT_W'(1);
      end
    end
  end

  assign head = ent_q[head_q];

`ifdef MS_RDATA_BYPASS_EN
  assign byp_hit = consume && (tgt_idx == head_q);
  assign ld_data = byp_hit ? data_sram_rdata : head.data;
`else
  assign byp_hit = 1'b0;
  assign ld_data = head.data;
`endif

  assign head_done = head.valid && (!head.is_load || head.data_vld || byp_hit);
  assign ld_off    = head.alu[1:0];
  assign sel_byte  = ld_data[{ld_off, 3'b000} +: 8];
  assign sel_half  = ld_off[1] ? ld_data[31:16] : ld_data[15:0];

  always_comb begin
    res = head.alu;
    we  = {4{head.gr_we}};
    if (head.is_load) begin
      case (head.ld_type)
        LdLb:    res = {{24{sel_byte[7]}}, sel_byte};
        LdLbu:   res = {24'b0, sel_byte};
        LdLh:    res = {{16{sel_half[15]}}, sel_half};
        LdLhu:   res = {16'b0, sel_half};
        LdLw:    res = ld_data;
        LdLwl: begin
          res = ld_data << {~ld_off, 3'b000};
          we  = 4'b1111 << ~ld_off;
        end
        LdLwr: begin
          res = ld_data >> {ld_off, 3'b000};
          we  = 4'b1111 >> ld_off;
        end
        default: ;
      endcase
    end
  end

  assign ms_to_ws_valid    = head_done;
  assign ms_pc             = head.pc;
  assign ms_final_result   = res;
  assign ms_rf_we          = we;
  assign ms_dest           = head.dest;
  assign ms_ex             = head.valid && head.ex;
  assign ms_side           = head.side;
  assign ms_handle_ex      = head.valid && (head.ex || head.eret);
  assign ms_ld_outstanding = wait_cnt + drop_q;

  always_comb begin
    ent_d   = ent_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    if (consume) begin
      ent_d[tgt_idx].data_vld = 1'b1;
      ent_d[tgt_idx].data     = data_sram_rdata;
    end
    if (pop) begin
      ent_d[head_q].valid = 1'b0;
      head_d              = head_q + PW'(1);
    end
    if (push) begin
      ent_d[tail_q].valid    = 1'b1;
      ent_d[tail_q].is_load  = (es_ld_type != 3'd0) && !es_ex;
      ent_d[tail_q].data_vld = 1'b0;
      ent_d[tail_q].pc       = es_pc;
      ent_d[tail_q].alu      = es_alu_result;
      ent_d[tail_q].dest     = es_dest;
      ent_d[tail_q].gr_we    = es_gr_we;
      ent_d[tail_q].ld_type  = ld_e'(es_ld_type);
      ent_d[tail_q].ex       = es_ex;
      ent_d[tail_q].eret     = es_eret;
      ent_d[tail_q].side     = es_side;
      ent_d[tail_q].data     = '0;
      tail_d                 = tail_q + PW'(1);
    end
    if (ws_handle_ex) begin
      for (int i = 0; i < DEPTH; i++) ent_d[i].valid = 1'b0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
    // wait_cnt already includes a load that takes this cycle's data, so take it back out.
    drop_d = drop_q + (ws_handle_ex ? wait_cnt : '0) - CNT_W'(ws_handle_ex && consume)
             - CNT_W'(drop_dec);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      drop_q  <= '0;
    end else begin
      ent_q   <= ent_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      drop_q  <= drop_d;
    end
  end

  assert property (@(posedge clk) disable iff (!resetn)
    data_sram_dataok |-> (drop_q != '0 || tgt_found));
  assert property (@(posedge clk) disable iff (!resetn) drop_q <= CNT_W'(DEPTH));

endmodule

// File: tb/tb_mem_stage_mq.sv
// Directed self-checking bench for mem_stage_mq; a negedge monitor records retired entries.
`timescale 1ns/1ps
module tb_mem_stage_mq;
  localparam int unsigned DEPTH  = 2;
  localparam int unsigned SIDE_W = 64;
  localparam int unsigned CNT_W  = $clog2(DEPTH) + 2;
`ifdef MS_RDATA_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic clk = 1'b0, resetn = 1'b0;
  logic es_to_ms_valid, ms_allowin, es_gr_we, es_ex, es_eret, ws_allowin, ms_to_ws_valid;
  logic [31:0] es_pc, es_alu_result, ms_pc, ms_final_result, data_sram_rdata;
  logic [4:0] es_dest, ms_dest;
  logic [2:0] es_ld_type;
  logic [SIDE_W-1:0] es_side, ms_side;
  logic [3:0] ms_rf_we;
  logic ms_ex, ms_handle_ex, data_sram_dataok, ws_handle_ex;
  logic [CNT_W-1:0] ms_ld_outstanding;

  int total = 0;
  int bad = 0;
  logic [31:0] ret_pc [$];
  logic [31:0] ret_res [$];
  logic [3:0]  ret_we [$];

  mem_stage_mq #(.DEPTH(DEPTH), .SIDE_W(SIDE_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .resetn(resetn), .es_to_ms_valid(es_to_ms_valid), .ms_allowin(ms_allowin),
    .es_pc(es_pc), .es_alu_result(es_alu_result), .es_dest(es_dest), .es_gr_we(es_gr_we),
    .es_ld_type(es_ld_type), .es_ex(es_ex), .es_eret(es_eret), .es_side(es_side),
    .ws_allowin(ws_allowin), .ms_to_ws_valid(ms_to_ws_valid), .ms_pc(ms_pc),
    .ms_final_result(ms_final_result), .ms_rf_we(ms_rf_we), .ms_dest(ms_dest), .ms_ex(ms_ex),
    .ms_side(ms_side), .ms_handle_ex(ms_handle_ex), .data_sram_rdata(data_sram_rdata),
    .data_sram_dataok(data_sram_dataok), .ws_handle_ex(ws_handle_ex),
    .ms_ld_outstanding(ms_ld_outstanding)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (resetn && ms_to_ws_valid && ws_allowin) begin
      ret_pc.push_back(ms_pc);
      ret_res.push_back(ms_final_result);
      ret_we.push_back(ms_rf_we);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    es_to_ms_valid = 1'b0; es_pc = '0; es_alu_result = '0; es_dest = '0; es_gr_we = 1'b0;
    es_ld_type = '0; es_ex = 1'b0; es_eret = 1'b0; es_side = '0;
    data_sram_rdata = '0; data_sram_dataok = 1'b0; ws_handle_ex = 1'b0;
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] alu, input logic [2:0] lt,
                       input logic ex, input logic [4:0] dest);
    es_to_ms_valid = 1'b1; es_pc = pc; es_alu_result = alu; es_ld_type = lt; es_ex = ex;
    es_dest = dest; es_gr_we = 1'b1; es_side = {pc, alu};
  endtask

  task automatic clr_ret();
    ret_pc.delete(); ret_res.delete(); ret_we.delete();
  endtask

  task automatic test_reset();
    clr_in(); ws_allowin = 1'b1; resetn = 1'b0;
    #12;
    total++; if (ms_allowin !== 1'b1) begin bad++;
      $display("FAIL reset_allowin got=%0h exp=1", ms_allowin); end
    total++; if (ms_to_ws_valid !== 1'b0) begin bad++;
      $display("FAIL reset_valid got=%0h exp=0", ms_to_ws_valid); end
    total++; if (ms_final_result !== 32'h0) begin bad++;
      $display("FAIL reset_result got=%0h exp=0", ms_final_result); end
    total++; if (ms_rf_we !== 4'h0) begin bad++;
      $display("FAIL reset_we got=%0h exp=0", ms_rf_we); end
    total++; if (ms_ld_outstanding !== '0) begin bad++;
      $display("FAIL reset_outstanding got=%0d exp=0", ms_ld_outstanding); end
    total++; if (ms_handle_ex !== 1'b0 || ms_pc !== 32'h0) begin bad++;
      $display("FAIL reset_head got=%0h/%0h exp=0/0", ms_handle_ex, ms_pc); end
    cyc(); resetn = 1'b1;
    cyc();
  endtask

  task automatic test_lw();
    clr_ret(); ws_allowin = 1'b1;
    cyc(); drive(32'h1000, 32'h100, 3'd5, 1'b0, 5'd3); #1;
    total++; if (ms_allowin !== 1'b1) begin bad++;
      $display("FAIL lw_allowin got=%0h exp=1", ms_allowin); end
    cyc(); es_to_ms_valid = 1'b0; #1;
    total++; if (ms_ld_outstanding !== CNT_W'(1)) begin bad++;
      $display("FAIL lw_outstanding got=%0d exp=1", ms_ld_outstanding); end
    cyc(); #1;
    total++; if (ms_to_ws_valid !== 1'b0) begin bad++;
      $display("FAIL lw_wait_valid got=%0h exp=0", ms_to_ws_valid); end
    cyc(); data_sram_dataok = 1'b1; data_sram_rdata = 32'hDEADBEEF; #1;
    total++; if (ms_to_ws_valid !== BYP) begin bad++;
      $display("FAIL lw_dataok_cycle_valid got=%0h exp=%0h", ms_to_ws_valid, BYP); end
    cyc(); data_sram_dataok = 1'b0; #1;
    total++; if (ms_to_ws_valid !== !BYP) begin bad++;
      $display("FAIL lw_next_cycle_valid got=%0h exp=%0h", ms_to_ws_valid, !BYP); end
    cyc(); cyc();
    total++; if (ret_res.size() != 1) begin bad++;
      $display("FAIL lw_retired_count got=%0d exp=1", ret_res.size()); end
    else begin
      total++; if (ret_res[0] !== 32'hDEADBEEF || ret_we[0] !== 4'hF) begin bad++;
        $display("FAIL lw_data got=%0h/%0h exp=deadbeef/f", ret_res[0], ret_we[0]); end
    end
    total++; if (ms_ld_outstanding !== '0) begin bad++;
      $display("FAIL lw_outstanding_end got=%0d exp=0", ms_ld_outstanding); end
  endtask

  task automatic test_extract();
    logic [2:0]  lt  [8] = '{3'd1, 3'd2, 3'd6, 3'd3, 3'd4, 3'd7, 3'd1, 3'd0};
    logic [31:0] alu [8] = '{32'h203, 32'h203, 32'h201, 32'h202, 32'h202, 32'h202, 32'h201,
                             32'h1234};
    logic [31:0] dat [8] = '{32'h80112233, 32'h80112233, 32'hAABBCCDD, 32'h80112233,
                             32'h80112233, 32'hAABBCCDD, 32'h80112233, 32'h0};
    logic [31:0] exr [8] = '{32'hFFFFFF80, 32'h00000080, 32'hCCDD0000, 32'hFFFF8011,
                             32'h00008011, 32'h0000AABB, 32'h00000022, 32'h00001234};
    logic [3:0]  exw [8] = '{4'hF, 4'hF, 4'hC, 4'hF, 4'hF, 4'h3, 4'hF, 4'hF};
    clr_ret(); ws_allowin = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc(); drive(32'h2000 + 32'(i * 4), alu[i], lt[i], 1'b0, 5'd4);
      cyc(); es_to_ms_valid = 1'b0;
      data_sram_dataok = (lt[i] != 3'd0); data_sram_rdata = dat[i];
      cyc(); data_sram_dataok = 1'b0;
      cyc(); cyc();
    end
    total++; if (ret_res.size() != 8) begin bad++;
      $display("FAIL extract_count got=%0d exp=8", ret_res.size()); end
    for (int i = 0; i < 8 && i < ret_res.size(); i++) begin
      total++; if (ret_res[i] !== exr[i]) begin bad++;
        $display("FAIL extract_result[%0d] got=%0h exp=%0h", i, ret_res[i], exr[i]); end
      total++; if (ret_we[i] !== exw[i]) begin bad++;
        $display("FAIL extract_we[%0d] got=%0h exp=%0h", i, ret_we[i], exw[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_pc  [3] = '{32'h3000, 32'h3004, 32'h3008};
    logic [31:0] exp_res [3] = '{32'h1, 32'h2, 32'h55};
    clr_ret(); ws_allowin = 1'b0;
    cyc(); drive(32'h3000, 32'h300, 3'd5, 1'b0, 5'd5);
    cyc(); drive(32'h3004, 32'h304, 3'd5, 1'b0, 5'd6); #1;
    total++; if (ms_allowin !== 1'b1) begin bad++;
      $display("FAIL b2b_allowin_one got=%0h exp=1", ms_allowin); end
    cyc(); drive(32'h3008, 32'h55, 3'd0, 1'b0, 5'd7);
    data_sram_dataok = 1'b1; data_sram_rdata = 32'h1; #1;
    total++; if (ms_allowin !== 1'b0) begin bad++;
      $display("FAIL b2b_allowin_full got=%0h exp=0", ms_allowin); end
    cyc(); data_sram_rdata = 32'h2; #1;
    total++; if (ms_ld_outstanding !== CNT_W'(1)) begin bad++;
      $display("FAIL b2b_outstanding got=%0d exp=1", ms_ld_outstanding); end
    cyc(); data_sram_dataok = 1'b0; #1;
    total++; if (ms_to_ws_valid !== 1'b1 || ms_allowin !== 1'b0) begin bad++;
      $display("FAIL b2b_full_complete got=%0h/%0h exp=1/0", ms_to_ws_valid, ms_allowin); end
    ws_allowin = 1'b1;
    cyc(); #1;
    total++; if (ms_allowin !== 1'b1) begin bad++;
      $display("FAIL b2b_allowin_after_pop got=%0h exp=1", ms_allowin); end
    cyc(); es_to_ms_valid = 1'b0;
    cyc(); cyc();
    total++; if (ret_res.size() != 3) begin bad++;
      $display("FAIL b2b_count got=%0d exp=3", ret_res.size()); end
    for (int i = 0; i < 3 && i < ret_res.size(); i++) begin
      total++; if (ret_res[i] !== exp_res[i] || ret_pc[i] !== exp_pc[i]) begin bad++;
        $display("FAIL b2b_order[%0d] got=%0h@%0h exp=%0h@%0h", i, ret_res[i], ret_pc[i],
                 exp_res[i], exp_pc[i]); end
    end
  endtask

  task automatic test_flush_drop();
    clr_ret(); ws_allowin = 1'b1;
    cyc(); drive(32'h4000, 32'h400, 3'd5, 1'b0, 5'd1);
    cyc(); drive(32'h4004, 32'h404, 3'd5, 1'b0, 5'd2);
    cyc(); es_to_ms_valid = 1'b0; ws_handle_ex = 1'b1; #1;
    total++; if (ms_ld_outstanding !== CNT_W'(2)) begin bad++;
      $display("FAIL flush_pre_outstanding got=%0d exp=2", ms_ld_outstanding); end
    cyc(); ws_handle_ex = 1'b0; #1;
    total++; if (ms_to_ws_valid !== 1'b0 || ms_allowin !== 1'b1) begin bad++;
      $display("FAIL flush_empty got=%0h/%0h exp=0/1", ms_to_ws_valid, ms_allowin); end
    total++; if (ms_ld_outstanding !== CNT_W'(2)) begin bad++;
      $display("FAIL flush_outstanding got=%0d exp=2", ms_ld_outstanding); end
    data_sram_dataok = 1'b1; data_sram_rdata = 32'hBAD1;
    cyc(); #1;
    total++; if (ms_ld_outstanding !== CNT_W'(1)) begin bad++;
      $display("FAIL flush_drop1 got=%0d exp=1", ms_ld_outstanding); end
    data_sram_rdata = 32'hBAD2; drive(32'h4008, 32'h408, 3'd5, 1'b0, 5'd3);
    cyc(); es_to_ms_valid = 1'b0; data_sram_dataok = 1'b0; #1;
    total++; if (ms_ld_outstanding !== CNT_W'(1) || ms_to_ws_valid !== 1'b0) begin bad++;
      $display("FAIL flush_new_wait got=%0d/%0h exp=1/0", ms_ld_outstanding, ms_to_ws_valid); end
    cyc(); data_sram_dataok = 1'b1; data_sram_rdata = 32'h33; #1;
    total++; if (ms_to_ws_valid !== BYP) begin bad++;
      $display("FAIL flush_third_valid got=%0h exp=%0h", ms_to_ws_valid, BYP); end
    cyc(); data_sram_dataok = 1'b0; #1;
    total++; if (ms_ld_outstanding !== '0) begin bad++;
      $display("FAIL flush_end_outstanding got=%0d exp=0", ms_ld_outstanding); end
    cyc(); cyc();
    total++; if (ret_res.size() != 1) begin bad++;
      $display("FAIL flush_retired_count got=%0d exp=1", ret_res.size()); end
    else begin
      total++; if (ret_res[0] !== 32'h33 || ret_pc[0] !== 32'h4008) begin bad++;
        $display("FAIL flush_third_data got=%0h@%0h exp=33@4008", ret_res[0], ret_pc[0]); end
    end
  endtask

  task automatic test_flush_consume();
    clr_ret(); ws_allowin = 1'b0;
    cyc(); drive(32'h5000, 32'h500, 3'd5, 1'b0, 5'd1);
    cyc(); drive(32'h5004, 32'h504, 3'd5, 1'b0, 5'd2);
    cyc(); es_to_ms_valid = 1'b0; ws_handle_ex = 1'b1;
    data_sram_dataok = 1'b1; data_sram_rdata = 32'h77;
    cyc(); ws_handle_ex = 1'b0; data_sram_dataok = 1'b0; #1;
    total++; if (ms_ld_outstanding !== CNT_W'(1) || ms_to_ws_valid !== 1'b0) begin bad++;
      $display("FAIL fc_drop got=%0d/%0h exp=1/0", ms_ld_outstanding, ms_to_ws_valid); end
    cyc(); data_sram_dataok = 1'b1; data_sram_rdata = 32'h88;
    cyc(); data_sram_dataok = 1'b0; #1;
    total++; if (ms_ld_outstanding !== '0) begin bad++;
      $display("FAIL fc_drained got=%0d exp=0", ms_ld_outstanding); end
    drive(32'h5008, 32'h50C, 3'd5, 1'b1, 5'd3);
    cyc(); es_to_ms_valid = 1'b0; #1;
    total++; if (ms_to_ws_valid !== 1'b1 || ms_handle_ex !== 1'b1 || ms_ex !== 1'b1) begin bad++;
      $display("FAIL fc_ex_head got=%0h%0h%0h exp=111", ms_to_ws_valid, ms_handle_ex, ms_ex); end
    total++; if (ms_ld_outstanding !== '0) begin bad++;
      $display("FAIL fc_ex_outstanding got=%0d exp=0", ms_ld_outstanding); end
    ws_allowin = 1'b1;
    cyc(); #1;
    total++; if (ms_to_ws_valid !== 1'b0 || ms_handle_ex !== 1'b0) begin bad++;
      $display("FAIL fc_ex_popped got=%0h/%0h exp=0/0", ms_to_ws_valid, ms_handle_ex); end
    total++; if (ret_pc.size() != 1) begin bad++;
      $display("FAIL fc_retired_count got=%0d exp=1", ret_pc.size()); end
  endtask

  task automatic test_stall_reset();
    clr_ret(); ws_allowin = 1'b0;
    cyc(); drive(32'h6000, 32'hABC, 3'd0, 1'b0, 5'd7);
    cyc(); drive(32'h6004, 32'hDEF, 3'd0, 1'b0, 5'd8);
    cyc(); es_to_ms_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      total++; if (ms_to_ws_valid !== 1'b1 || ms_final_result !== 32'hABC) begin bad++;
        $display("FAIL stall_head[%0d] got=%0h/%0h exp=1/abc", k, ms_to_ws_valid,
                 ms_final_result); end
      total++; if (ms_pc !== 32'h6000 || ms_dest !== 5'd7 || ms_allowin !== 1'b0) begin bad++;
        $display("FAIL stall_fields[%0d] got=%0h/%0h/%0h exp=6000/7/0", k, ms_pc, ms_dest,
                 ms_allowin); end
      total++; if (ms_side !== {32'h6000, 32'hABC}) begin bad++;
        $display("FAIL stall_side[%0d] got=%0h exp=%0h", k, ms_side, {32'h6000, 32'hABC}); end
      cyc();
    end
    ws_allowin = 1'b1;
    cyc(); cyc(); ws_allowin = 1'b0;
    total++; if (ret_res.size() != 2) begin bad++;
      $display("FAIL stall_count got=%0d exp=2", ret_res.size()); end
    else begin
      total++; if (ret_res[0] !== 32'hABC || ret_res[1] !== 32'hDEF) begin bad++;
        $display("FAIL stall_order got=%0h,%0h exp=abc,def", ret_res[0], ret_res[1]); end
    end
    cyc(); drive(32'h7000, 32'h111, 3'd0, 1'b0, 5'd9);
    cyc(); drive(32'h7004, 32'h700, 3'd5, 1'b0, 5'd10);
    cyc(); es_to_ms_valid = 1'b0; #1;
    total++; if (ms_allowin !== 1'b0 || ms_ld_outstanding !== CNT_W'(1)) begin bad++;
      $display("FAIL prereset got=%0h/%0d exp=0/1", ms_allowin, ms_ld_outstanding); end
    #1 resetn = 1'b0;
    #1;
    total++; if (ms_to_ws_valid !== 1'b0 || ms_allowin !== 1'b1) begin bad++;
      $display("FAIL async_reset got=%0h/%0h exp=0/1", ms_to_ws_valid, ms_allowin); end
    total++; if (ms_ld_outstanding !== '0 || ms_final_result !== 32'h0) begin bad++;
      $display("FAIL async_reset_clear got=%0d/%0h exp=0/0", ms_ld_outstanding,
               ms_final_result); end
    cyc(); resetn = 1'b1;
    cyc();
  endtask

  initial begin
    clr_in();
    ws_allowin = 1'b1;
    test_reset();
    test_lw();
    test_extract();
    test_back_to_back();
    test_flush_drop();
    test_flush_consume();
    test_stall_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_stage_mq.md
Name: mem_stage_mq

Overview:
- Multi-entry MEM pipeline stage: successor to the single-slot MEM stage.
- Holds up to DEPTH in-flight instructions, so EX can issue back-to-back loads without waiting for data_sram_dataok.
- Matches in-order data responses to the oldest waiting load and performs sub-word/unaligned load extraction.
- Retires entries in program order to WB; on a WB exception flush it discards responses that still arrive for cancelled loads.

Parameters:
- DEPTH, 2, queue entries; power of two, >=2.
- SIDE_W, 64, width of opaque passthrough bus (cp0 addr/wdata, badvaddr, bd, exccode, mtc0, res_from_cp0).
- CNT_W, $clog2(DEPTH)+2, width of counters.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- es_to_ms_valid  in  1  EX entry valid.
- ms_allowin  out  1  stage can accept an entry this cycle.
- es_pc  in  32  instruction PC.
- es_alu_result  in  32  ALU result / effective address (low 2 bits used for alignment).
- es_dest  in  5  destination register.
- es_gr_we  in  1  register write enable.
- es_ld_type  in  3  0 none, 1 lb, 2 lbu, 3 lh, 4 lhu, 5 lw, 6 lwl, 7 lwr.
- es_ex  in  1  EX-detected exception (no memory request was issued).
- es_eret  in  1  eret instruction.
- es_side  in  SIDE_W  passthrough field.
- ws_allowin  in  1  WB can accept.
- ms_to_ws_valid  out  1  head entry is complete.
- ms_pc  out  32  head PC.
- ms_final_result  out  32  extracted load data or alu_result.
- ms_rf_we  out  4  byte write enables.
- ms_dest  out  5  head destination register.
- ms_ex  out  1  head exception.
- ms_side  out  SIDE_W  head passthrough field.
- ms_handle_ex  out  1  head is valid and (ex or eret).
- data_sram_rdata  in  32  response data.
- data_sram_dataok  in  1  response strobe; responses always arrive in request order.
- ws_handle_ex  in  1  flush request from WB.
- ms_ld_outstanding  out  CNT_W  loads awaiting data plus pending drops.

Behaviour:
- Reset: queue empty, drop_cnt=0. All outputs 0, except ms_allowin=1.
- Queue: circular buffer with head/tail pointers and count.
  - Push when es_to_ms_valid && ms_allowin.
  - Pop when ms_to_ws_valid && ws_allowin.
  - ms_allowin = (count != DEPTH). It is registered-only and has no combinational path from ws_allowin.
- A load entry is one with ld_type != 0 && !es_ex. It waits for data.
  - Non-load and excepted entries are complete on arrival.
- Response matching:
  - If drop_cnt > 0, data_ok only decrements drop_cnt.
  - Otherwise data_ok writes rdata into the oldest load entry with data_vld=0.
  - data_ok with no waiting entry and drop_cnt=0 is an error: ignored, with an assertion in simulation.
- Head output is always driven from the head entry. ms_to_ws_valid = head valid && (complete || bypass hit, see option).
- Extraction, with a = alu_result[1:0]:
  - lb/lbu: byte a, sign/zero extended.
  - lh/lhu: halfword a[1], sign/zero extended.
  - lw: whole word.
  - lwl: data << 8*(3-a), rf_we = {1111} << (3-a), truncated to 4 bits.
  - lwr: data >> 8*a, rf_we = 1111 >> a.
  - Otherwise rf_we = {4{gr_we}} and result = alu_result.
- Flush (ws_handle_ex=1 at an edge):
  - All entries are invalidated and count/pointers are cleared.
  - A push in the same cycle is discarded.
  - drop_cnt += (waiting loads) − (1 if data_ok is consumed by an entry this cycle).
  - A pop in the same cycle still completes.
- drop_cnt never exceeds DEPTH. Its ++ and -- in the same cycle net out.
- Push into an empty queue plus data_ok in the same cycle: data_ok belongs to an older request or a drop, never to the newly pushed entry.
- resetn low mid-operation: everything clears immediately, including drop_cnt. Responses after reset are the bus's responsibility.

Optional Feature:
- MS_RDATA_BYPASS_EN defined: when data_ok targets the head entry, extraction uses data_sram_rdata in that same cycle. ms_to_ws_valid asserts in the data_ok cycle, with zero added latency.
- Undefined: data is registered first and the head completes one cycle after data_ok. This removes the rdata-to-WB combinational path.

Test Plan:
- Single lw, addr 0x100, data_ok 2 cycles later with 0xDEADBEEF -> ms_final_result=0xDEADBEEF, rf_we=1111. ms_to_ws_valid in the data_ok cycle (bypass) or one cycle later (no bypass).
- lb at addr low=3, data 0x80112233 -> result 0xFFFFFF80. lbu -> 0x00000080. lwl a=1, data 0xAABBCCDD -> 0xCCDD0000, rf_we=1100.
- DEPTH=2: two back-to-back loads then an add, with responses 0x1 and 0x2 -> retired in order 0x1, 0x2, alu_result. ms_allowin=0 while count=2.
- Two loads outstanding, ws_handle_ex pulsed -> queue empties, ms_ld_outstanding=2. Next two data_ok are dropped. A third load pushed afterwards receives the third data_ok.
- Flush in the same cycle as data_ok for the oldest of two waiting loads -> drop_cnt=1. Pushing load with es_ex=1 -> retired immediately, ms_handle_ex=1.
- WB stall (ws_allowin=0) for 5 cycles with complete head -> outputs held stable, no entry lost. resetn asserted mid-stall -> ms_to_ws_valid=0 and ms_allowin=1 without waiting for a clock edge.
